// File: rtl/hockey_core_p_pkg.sv
// Shared types and helpers for the air-hockey engine: FSM states, shot
// direction codes and the paddle-row clamp.
package hockey_pkg;

   typedef enum logic [3:0] {
      IDLE,
      SERVE_A,
      SERVE_B,
      MOVE_AB,
      MOVE_BA,
      RESP_A,
      RESP_B,
      GOAL_A,
      GOAL_B,
      OVER
   } state_t;

   localparam logic [1:0] DIR_STRAIGHT = 2'd0;
   localparam logic [1:0] DIR_UP       = 2'd1;
   localparam logic [1:0] DIR_DOWN     = 2'd2;

   // Rows beyond the table are pinned to the top row.
   function automatic int clamp_y(input int y, input int y_max);
      return (y >= y_max) ? (y_max - 1) : y;
   endfunction

endpackage

// File: rtl/hockey_core_p_if.sv
// Player-input and display-output bundle of the air-hockey engine.
// The slave side is the game core; the master side drives buttons and reads the display.
interface hockey_core_p_if #(
   parameter int CW = 3,
   parameter int SW = 2
);

   logic          BTN_A;
   logic          BTN_B;
   logic [1:0]    DIR_A;
   logic [1:0]    DIR_B;
   logic [CW-1:0] Y_in_A;
   logic [CW-1:0] Y_in_B;
   logic [CW-1:0] X_COORD;
   logic [CW-1:0] Y_COORD;
   logic [SW-1:0] SCORE_A;
   logic [SW-1:0] SCORE_B;
   logic          SERVER;
   logic          GOAL;
   logic          GAME_OVER;
   logic          WINNER;

   modport master (
      output BTN_A, BTN_B, DIR_A, DIR_B, Y_in_A, Y_in_B,
      input  X_COORD, Y_COORD, SCORE_A, SCORE_B, SERVER, GOAL, GAME_OVER, WINNER
   );

   modport slave (
      input  BTN_A, BTN_B, DIR_A, DIR_B, Y_in_A, Y_in_B,
      output X_COORD, Y_COORD, SCORE_A, SCORE_B, SERVER, GOAL, GAME_OVER, WINNER
   );

endinterface

// File: rtl/hockey_core_p_tick_gen.sv
// Step-rate generator: one-cycle tick every `period` cycles, re-phased by restart.
module hockey_tick_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic        restart,
   input  logic [15:0] period,
   output logic        tick
);

   logic [15:0] cnt;

   // The tick only looks at the counter, so restart (derived from the FSM's
   // next state, which depends on tick) does not close a combinational loop.
   assign tick = (cnt >= (period - 16'd1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (restart || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/hockey_core_p.sv
// Two-player air-hockey engine: serve, puck motion with wall bounce, returns
// with per-rally speed-up, goal display and configurable win score.
module hockey_core_p
   import hockey_pkg::*;
#(
   parameter int X_MAX      = 5,
   parameter int Y_MAX      = 5,
   parameter int CW         = 3,
   parameter int SW         = 2,
   parameter int WIN_SCORE  = 3,
   parameter int TICK_DIV   = 100,
   parameter int TICK_MIN   = 25,
   parameter int SPEED_STEP = 15,
   parameter int RESP_TICKS = 2,
   parameter int GOAL_TICKS = 4
) (
   input  logic           clk,
   input  logic           rst,
   hockey_core_p_if.slave bus
);

   localparam logic [SW-1:0] WIN = SW'(WIN_SCORE);

   state_t        state, state_n;
   logic [CW-1:0] x_r, x_n, y_r, y_n, y_step, ya_c, yb_c;
   logic [1:0]    dir_r, dir_n, dir_step, da_c, db_c;
   logic [15:0]   period_r, period_n, period_fast;
   logic [SW-1:0] sa_r, sa_n, sb_r, sb_n;
   logic          server_r, server_n, winner_r, winner_n;
   logic [7:0]    phase_r, phase_n;
   logic          btn_a_d, btn_a_q, btn_b_d, btn_b_q;
   logic          press_a, press_b, tick, restart;

   assign press_a = btn_a_d & ~btn_a_q;
   assign press_b = btn_b_d & ~btn_b_q;

   assign ya_c = CW'(clamp_y(32'(bus.Y_in_A), Y_MAX));
   assign yb_c = CW'(clamp_y(32'(bus.Y_in_B), Y_MAX));
   assign da_c = (bus.DIR_A == 2'd3) ? DIR_STRAIGHT : bus.DIR_A;
   assign db_c = (bus.DIR_B == 2'd3) ? DIR_STRAIGHT : bus.DIR_B;

   assign period_fast = (period_r > 16'(TICK_MIN + SPEED_STEP)) ?
                        (period_r - 16'(SPEED_STEP)) : 16'(TICK_MIN);

   assign restart = (state_n != state);

   hockey_tick_gen u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .period  (period_r),
      .tick    (tick)
   );

   // Next row for one puck step; a step that would leave the table reflects.
   always_comb begin
      y_step   = y_r;
      dir_step = dir_r;
      case (dir_r)
         DIR_UP: begin
            if (y_r == CW'(Y_MAX - 1)) begin
               y_step   = y_r - CW'(1);
               dir_step = DIR_DOWN;
            end else begin
               y_step = y_r + CW'(1);
            end
         end
         DIR_DOWN: begin
            if (y_r == '0) begin
               y_step   = y_r + CW'(1);
               dir_step = DIR_UP;
            end else begin
               y_step = y_r - CW'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_n  = state;
      x_n      = x_r;
      y_n      = y_r;
      dir_n    = dir_r;
      period_n = period_r;
      sa_n     = sa_r;
      sb_n     = sb_r;
      server_n = server_r;
      winner_n = winner_r;
      phase_n  = phase_r;

      case (state)
         IDLE: begin
            x_n = '0;
            y_n = '0;
            if (press_a) begin
               state_n  = SERVE_A;
               server_n = 1'b0;
            end else if (press_b) begin
               state_n  = SERVE_B;
               server_n = 1'b1;
            end
         end
         SERVE_A: begin
            if (press_a) begin
               x_n      = '0;
               y_n      = ya_c;
               dir_n    = da_c;
               period_n = 16'(TICK_DIV);
               state_n  = MOVE_AB;
            end
         end
         SERVE_B: begin
            if (press_b) begin
               x_n      = CW'(X_MAX - 1);
               y_n      = yb_c;
               dir_n    = db_c;
               period_n = 16'(TICK_DIV);
               state_n  = MOVE_BA;
            end
         end
         MOVE_AB: begin
            if (tick) begin
               x_n   = x_r + CW'(1);
               y_n   = y_step;
               dir_n = dir_step;
               if (x_r == CW'(X_MAX - 2)) state_n = RESP_B;
            end
         end
         MOVE_BA: begin
            if (tick) begin
               x_n   = x_r - CW'(1);
               y_n   = y_step;
               dir_n = dir_step;
               if (x_r == CW'(1)) state_n = RESP_A;
            end
         end
         RESP_B: begin
            if (tick) phase_n = phase_r + 8'd1;
            if (press_b && (yb_c == y_r)) begin
               dir_n    = db_c;
               period_n = period_fast;
               state_n  = MOVE_BA;
            end else if (press_b || (tick && (phase_r == 8'(RESP_TICKS - 1)))) begin
               if (sa_r < WIN) sa_n = sa_r + SW'(1);
               state_n = GOAL_A;
            end
         end
         RESP_A: begin
            if (tick) phase_n = phase_r + 8'd1;
            if (press_a && (ya_c == y_r)) begin
               dir_n    = da_c;
               period_n = period_fast;
               state_n  = MOVE_AB;
            end else if (press_a || (tick && (phase_r == 8'(RESP_TICKS - 1)))) begin
               if (sb_r < WIN) sb_n = sb_r + SW'(1);
               state_n = GOAL_B;
            end
         end
         GOAL_A: begin
            if (tick) phase_n = phase_r + 8'd1;
            if (tick && (phase_r == 8'(GOAL_TICKS - 1))) begin
               if (sa_r == WIN) begin
                  state_n  = OVER;
                  winner_n = 1'b0;
                  x_n      = '0;
                  y_n      = '0;
               end else begin
                  state_n  = SERVE_B;
                  server_n = 1'b1;
               end
            end
         end
         GOAL_B: begin
            if (tick) phase_n = phase_r + 8'd1;
            if (tick && (phase_r == 8'(GOAL_TICKS - 1))) begin
               if (sb_r == WIN) begin
                  state_n  = OVER;
                  winner_n = 1'b1;
                  x_n      = '0;
                  y_n      = '0;
               end else begin
                  state_n  = SERVE_A;
                  server_n = 1'b0;
               end
            end
         end
         OVER: begin
            x_n = '0;
            y_n = '0;
         end
         default: state_n = IDLE;
      endcase

      // Response and goal windows count ticks from the moment they are entered.
      if (state_n != state) phase_n = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         x_r      <= '0;
         y_r      <= '0;
         dir_r    <= DIR_STRAIGHT;
         period_r <= 16'(TICK_DIV);
         sa_r     <= '0;
         sb_r     <= '0;
         server_r <= 1'b0;
         winner_r <= 1'b0;
         phase_r  <= '0;
         btn_a_d  <= 1'b0;
         btn_a_q  <= 1'b0;
         btn_b_d  <= 1'b0;
         btn_b_q  <= 1'b0;
      end else begin
         state    <= state_n;
         x_r      <= x_n;
         y_r      <= y_n;
         dir_r    <= dir_n;
         period_r <= period_n;
         sa_r     <= sa_n;
         sb_r     <= sb_n;
         server_r <= server_n;
         winner_r <= winner_n;
         phase_r  <= phase_n;
         btn_a_d  <= bus.BTN_A;
         btn_a_q  <= btn_a_d;
         btn_b_d  <= bus.BTN_B;
         btn_b_q  <= btn_b_d;
      end
   end

   assign bus.X_COORD   = x_r;
   assign bus.Y_COORD   = y_r;
   assign bus.SCORE_A   = sa_r;
   assign bus.SCORE_B   = sb_r;
   assign bus.SERVER    = server_r;
   assign bus.WINNER    = winner_r;
   assign bus.GOAL      = (state == GOAL_A) || (state == GOAL_B);
   assign bus.GAME_OVER = (state == OVER);

endmodule
